// File: rtl/log_stream_unpacker.sv
// Log stream receiver: reassembles multi-beat log records and unpacks them.
// Checks record framing and presents each good record on a valid/ready port.
//
// Ports:
//   sysClk, sysReset         clock, asynchronous active-high reset
//   sysLogTDATA/TVALID/TLAST stream input, MSB word first
//   sysLogTREADY             stream ready (low while a record is held)
//   recValid, recReady       record handshake toward the consumer
//   rec*                     unpacked record fields and pad-error flag
//   sysCountClear            synchronous clear of the three counters
//   recordCount              saturating count of good records
//   shortErrCount            saturating count of short records
//   longErrCount             saturating count of long records

module log_stream_unpacker #(
    parameter int TIMESTAMP_WIDTH     = 64,
    parameter int INTERLOCKS_PER_NODE = 64,
    parameter int AXI_WIDTH           = 32,
    parameter int ACQ_INDEX_WIDTH     = 3,
    localparam int MAX_OUTPUTS        = 16
) (
    input  logic                           sysClk,
    input  logic                           sysReset,
    input  logic [AXI_WIDTH-1:0]           sysLogTDATA,
    input  logic                           sysLogTVALID,
    input  logic                           sysLogTLAST,
    output logic                           sysLogTREADY,
    output logic                           recValid,
    input  logic                           recReady,
    output logic                           recStrobeFlag,
    output logic [ACQ_INDEX_WIDTH-1:0]     recAcqIndex,
    output logic [MAX_OUTPUTS-1:0]         recOutputState,
    output logic [TIMESTAMP_WIDTH-1:0]     recTimestamp,
    output logic [INTERLOCKS_PER_NODE-1:0] recInputState,
    output logic [INTERLOCKS_PER_NODE-1:0] recInputTransitions,
    output logic                           recPadError,
    input  logic                           sysCountClear,
    output logic [15:0]                    recordCount,
    output logic [15:0]                    shortErrCount,
    output logic [15:0]                    longErrCount
);

    localparam int REC_WIDTH = 1 + ACQ_INDEX_WIDTH + MAX_OUTPUTS
                             + TIMESTAMP_WIDTH + 2 * INTERLOCKS_PER_NODE;
    localparam int BEATS      = (REC_WIDTH + AXI_WIDTH - 1) / AXI_WIDTH;
    localparam int ASM_WIDTH  = BEATS * AXI_WIDTH;
    localparam int BEAT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(BEATS - 1);

    // Field positions inside the record, LSB first.
    localparam int TRN_LSB = 0;
    localparam int IST_LSB = TRN_LSB + INTERLOCKS_PER_NODE;
    localparam int TS_LSB  = IST_LSB + INTERLOCKS_PER_NODE;
    localparam int OUT_LSB = TS_LSB + TIMESTAMP_WIDTH;
    localparam int ACQ_LSB = OUT_LSB + MAX_OUTPUTS;
    localparam int STB_BIT = REC_WIDTH - 1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DISCARD = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [BEAT_WIDTH-1:0]   beat;
    logic [BEAT_WIDTH-1:0]   beat_next;
    logic [ASM_WIDTH-1:0]    asm_q;
    logic [ASM_WIDTH-1:0]    asm_next;
    logic [REC_WIDTH-1:0]    rec_bits;
    logic                    ready;
    logic                    fire;
    logic                    take;
    logic                    short_inc;
    logic                    long_inc;
    logic                    pad_bad;

    // Shift view including the beat on the bus, so the final beat is
    // part of the latched record without an extra cycle.
    assign asm_next = (asm_q << AXI_WIDTH) | ASM_WIDTH'(sysLogTDATA);
    assign rec_bits = asm_next[REC_WIDTH-1:0];
    assign pad_bad  = |(asm_next >> REC_WIDTH);

    assign fire         = sysLogTVALID && ready;
    assign sysLogTREADY = ready;
    assign recValid     = (state == HOLD);

    always_comb begin
        state_next = state;
        beat_next  = beat;
        ready      = 1'b1;
        take       = 1'b0;
        short_inc  = 1'b0;
        long_inc   = 1'b0;
        unique case (state)
            COLLECT: begin
                if (fire) begin
                    if (beat == LAST_BEAT) begin
                        beat_next = '0;
                        if (sysLogTLAST) begin
                            take       = 1'b1;
                            state_next = HOLD;
                        end else begin
                            long_inc   = 1'b1;
                            state_next = DISCARD;
                        end
                    end else if (sysLogTLAST) begin
                        short_inc = 1'b1;
                        beat_next = '0;
                    end else begin
                        beat_next = beat + 1'b1;
                    end
                end
            end
            DISCARD: begin
                // Overlong record: swallow the tail up to its TLAST.
                if (fire && sysLogTLAST) begin
                    state_next = COLLECT;
                    beat_next  = '0;
                end
            end
            HOLD: begin
                ready = 1'b0;
                if (recReady) begin
                    state_next = COLLECT;
                end
            end
            default: begin
                state_next = COLLECT;
                beat_next  = '0;
            end
        endcase
    end

    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            state <= COLLECT;
            beat  <= '0;
        end else begin
            state <= state_next;
            beat  <= beat_next;
        end
    end

    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            asm_q <= '0;
        end else if (fire) begin
            asm_q <= asm_next;
        end
    end

    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            recStrobeFlag       <= 1'b0;
            recAcqIndex         <= '0;
            recOutputState      <= '0;
            recTimestamp        <= '0;
            recInputState       <= '0;
            recInputTransitions <= '0;
            recPadError         <= 1'b0;
        end else if (take) begin
            recStrobeFlag       <= rec_bits[STB_BIT];
            recAcqIndex         <= rec_bits[ACQ_LSB +: ACQ_INDEX_WIDTH];
            recOutputState      <= rec_bits[OUT_LSB +: MAX_OUTPUTS];
            recTimestamp        <= rec_bits[TS_LSB +: TIMESTAMP_WIDTH];
            recInputState       <= rec_bits[IST_LSB +: INTERLOCKS_PER_NODE];
            recInputTransitions <= rec_bits[TRN_LSB +: INTERLOCKS_PER_NODE];
            recPadError         <= pad_bad;
        end
    end

    // Clear has priority over any increment in the same cycle.
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            recordCount   <= '0;
            shortErrCount <= '0;
            longErrCount  <= '0;
        end else if (sysCountClear) begin
            recordCount   <= '0;
            shortErrCount <= '0;
            longErrCount  <= '0;
        end else begin
            if (take && recordCount != 16'hFFFF) begin
                recordCount <= recordCount + 16'd1;
            end
            if (short_inc && shortErrCount != 16'hFFFF) begin
                shortErrCount <= shortErrCount + 16'd1;
            end
            if (long_inc && longErrCount != 16'hFFFF) begin
                longErrCount <= longErrCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_log_stream_unpacker.sv
// Bench for log_stream_unpacker: directed and randomized records
// checked against a frame-level model of the receiver.

module tb_log_stream_unpacker;

    localparam int TW = 64;
    localparam int IW = 64;
    localparam int AW = 32;
    localparam int XW = 3;
    localparam int OW = 16;
    localparam int HW = 1 + XW + OW;
    localparam int RW = HW + TW + 2 * IW;
    localparam int NB = (RW + AW - 1) / AW;
    localparam int FW = NB * AW;
    localparam int PW = FW - RW;

    typedef struct packed {
        logic [HW-1:0] hdr;
        logic [TW-1:0] ts;
        logic [IW-1:0] ist;
        logic [IW-1:0] itr;
        logic [PW-1:0] padv;
    } rec_t;

    logic          sysClk = 1'b0;
    logic          sysReset;
    logic [AW-1:0] sysLogTDATA;
    logic          sysLogTVALID;
    logic          sysLogTLAST;
    logic          sysLogTREADY;
    logic          recValid;
    logic          recReady;
    logic          recStrobeFlag;
    logic [XW-1:0] recAcqIndex;
    logic [OW-1:0] recOutputState;
    logic [TW-1:0] recTimestamp;
    logic [IW-1:0] recInputState;
    logic [IW-1:0] recInputTransitions;
    logic          recPadError;
    logic          sysCountClear;
    logic [15:0]   recordCount;
    logic [15:0]   shortErrCount;
    logic [15:0]   longErrCount;

    int n_chk = 0;
    int n_pass = 0;
    int m_rec = 0;
    int m_short = 0;
    int m_long = 0;
    int rdy_mode = 2;

    rec_t          exp_q[$];
    logic [AW-1:0] frame_q[$];
    logic [AW-1:0] tx_q[$];
    rec_t          mon_e;
    rec_t          r;
    rec_t          ra;
    rec_t          rb;

    log_stream_unpacker #(
        .TIMESTAMP_WIDTH    (TW),
        .INTERLOCKS_PER_NODE(IW),
        .AXI_WIDTH          (AW),
        .ACQ_INDEX_WIDTH    (XW)
    ) dut (
        .sysClk             (sysClk),
        .sysReset           (sysReset),
        .sysLogTDATA        (sysLogTDATA),
        .sysLogTVALID       (sysLogTVALID),
        .sysLogTLAST        (sysLogTLAST),
        .sysLogTREADY       (sysLogTREADY),
        .recValid           (recValid),
        .recReady           (recReady),
        .recStrobeFlag      (recStrobeFlag),
        .recAcqIndex        (recAcqIndex),
        .recOutputState     (recOutputState),
        .recTimestamp       (recTimestamp),
        .recInputState      (recInputState),
        .recInputTransitions(recInputTransitions),
        .recPadError        (recPadError),
        .sysCountClear      (sysCountClear),
        .recordCount        (recordCount),
        .shortErrCount      (shortErrCount),
        .longErrCount       (longErrCount)
    );

    always #5 sysClk = ~sysClk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%h want=%h", tag, got, want);
    endtask

    function automatic logic [15:0] sat16(input int c);
        return (c > 65535) ? 16'hFFFF : 16'(c);
    endfunction

    function automatic rec_t rand_rec(input bit allow_pad);
        rec_t x;
        x.hdr  = HW'($urandom);
        x.ts   = {$urandom, $urandom};
        x.ist  = {$urandom, $urandom};
        x.itr  = {$urandom, $urandom};
        x.padv = '0;
        if (allow_pad && $urandom_range(0, 7) == 0)
            x.padv = PW'($urandom_range(1, (1 << PW) - 1));
        return x;
    endfunction

    task automatic build(input rec_t x);
        logic [FW-1:0] f;
        f = {x.padv, x.hdr, x.ts, x.ist, x.itr};
        frame_q.delete();
        for (int i = 0; i < NB; i++)
            frame_q.push_back(f[FW-1-i*AW -: AW]);
    endtask

    // Records leave on any negedge where valid and ready are both high.
    always @(negedge sysClk) begin
        if (!sysReset && recValid && recReady) begin
            if (exp_q.size() == 0) begin
                chk("spurious_rec", 64'(recValid), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("hdr", 64'({recStrobeFlag, recAcqIndex, recOutputState}),
                    64'(mon_e.hdr));
                chk("timestamp", recTimestamp, mon_e.ts);
                chk("input_state", recInputState, mon_e.ist);
                chk("transitions", recInputTransitions, mon_e.itr);
                chk("pad_err", 64'(recPadError), 64'(|mon_e.padv));
            end
        end
    end

    initial begin
        recReady = 1'b0;
        forever begin
            @(posedge sysClk);
            #1;
            case (rdy_mode)
                0:       recReady = ($urandom_range(0, 3) != 0);
                1:       recReady = 1'b0;
                default: recReady = 1'b1;
            endcase
        end
    end

    task automatic send(input bit gaps, input bit clr_last,
                        input bit last_at_end);
        int  n;
        int  t;
        bit  acc;
        n = tx_q.size();
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    sysLogTVALID = 1'b0;
                    sysLogTDATA  = $urandom;
                    sysLogTLAST  = 1'($urandom_range(0, 1));
                    @(posedge sysClk);
                    #1;
                end
            end
            sysLogTDATA   = tx_q[i];
            sysLogTVALID  = 1'b1;
            sysLogTLAST   = last_at_end && (i == n - 1);
            sysCountClear = clr_last && (i == n - 1);
            acc = 1'b0;
            t   = 0;
            while (!acc && t < 200) begin
                @(negedge sysClk);
                acc = sysLogTREADY;
                @(posedge sysClk);
                #1;
                t++;
            end
            if (!acc) chk("beat_accept", 64'(acc), 64'd1);
        end
        sysLogTVALID  = 1'b0;
        sysLogTLAST   = 1'b0;
        sysCountClear = 1'b0;
    endtask

    task automatic send_good(input rec_t x, input bit gaps, input bit clr);
        build(x);
        tx_q = frame_q;
        exp_q.push_back(x);
        send(gaps, clr, 1'b1);
        if (clr) begin
            m_rec   = 0;
            m_short = 0;
            m_long  = 0;
        end else begin
            m_rec++;
        end
        @(negedge sysClk);
        chk("valid_latency", 64'(recValid), 64'd1);
        @(posedge sysClk);
        #1;
    endtask

    task automatic send_short(input int k);
        build(rand_rec(1'b1));
        tx_q = frame_q[0:k-1];
        send(1'b1, 1'b0, 1'b1);
        m_short++;
    endtask

    task automatic send_long(input int k);
        build(rand_rec(1'b1));
        tx_q = frame_q;
        while (tx_q.size() < k) tx_q.push_back($urandom);
        send(1'b1, 1'b0, 1'b1);
        m_long++;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || recValid) && t < 1000) begin
            @(posedge sysClk);
            #1;
            t++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_counts(input string tag);
        @(negedge sysClk);
        chk({tag, "_records"}, 64'(recordCount), 64'(sat16(m_rec)));
        chk({tag, "_short"}, 64'(shortErrCount), 64'(sat16(m_short)));
        chk({tag, "_long"}, 64'(longErrCount), 64'(sat16(m_long)));
        @(posedge sysClk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(recValid), 64'd0);
        chk({tag, "_tready"}, 64'(sysLogTREADY), 64'd1);
        chk({tag, "_hdr"}, 64'({recStrobeFlag, recAcqIndex, recOutputState}),
            64'd0);
        chk({tag, "_ts"}, recTimestamp, 64'd0);
        chk({tag, "_ist"}, recInputState, 64'd0);
        chk({tag, "_itr"}, recInputTransitions, 64'd0);
        chk({tag, "_pad"}, 64'(recPadError), 64'd0);
        chk({tag, "_cnt"}, {16'd0, recordCount, shortErrCount, longErrCount},
            64'd0);
    endtask

    initial begin
        sysReset      = 1'b1;
        sysLogTDATA   = '0;
        sysLogTVALID  = 1'b0;
        sysLogTLAST   = 1'b0;
        sysCountClear = 1'b0;
        repeat (2) @(posedge sysClk);
        @(negedge sysClk);
        check_reset_outputs("por");
        @(posedge sysClk);
        #1;
        sysReset = 1'b0;

        r.hdr  = {1'b1, 3'd5, 16'h000A};
        r.ts   = 64'h0123456789ABCDEF;
        r.ist  = 64'hFFFF0000FFFF0000;
        r.itr  = 64'h1;
        r.padv = '0;
        send_good(r, 1'b0, 1'b0);
        wait_idle();
        check_counts("good");

        send_short(4);
        send_good(rand_rec(1'b0), 1'b1, 1'b0);
        wait_idle();
        check_counts("short");

        send_long(9);
        send_good(rand_rec(1'b0), 1'b1, 1'b0);
        wait_idle();
        check_counts("long");

        rdy_mode = 1;
        repeat (2) @(posedge sysClk);
        #1;
        ra = rand_rec(1'b0);
        rb = rand_rec(1'b0);
        send_good(ra, 1'b0, 1'b0);
        fork
            send_good(rb, 1'b0, 1'b0);
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge sysClk);
                    chk("bp_tready", 64'(sysLogTREADY), 64'd0);
                    chk("bp_valid", 64'(recValid), 64'd1);
                    chk("bp_ts", recTimestamp, ra.ts);
                    chk("bp_ist", recInputState, ra.ist);
                end
                rdy_mode = 2;
            end
        join
        wait_idle();
        check_counts("bp");

        r = rand_rec(1'b0);
        r.padv = PW'(1 << (PW - 1));
        send_good(r, 1'b0, 1'b0);
        wait_idle();
        check_counts("pad");

        rdy_mode = 0;
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 9))
                0:       send_short($urandom_range(1, NB - 1));
                1:       send_long($urandom_range(NB + 1, NB + 3));
                default: send_good(rand_rec(1'b1), 1'b1, 1'b0);
            endcase
            wait_idle();
            check_counts("rand");
        end

        build(rand_rec(1'b0));
        tx_q = frame_q[0:2];
        send(1'b1, 1'b0, 1'b0);
        sysReset = 1'b1;
        m_rec    = 0;
        m_short  = 0;
        m_long   = 0;
        @(negedge sysClk);
        check_reset_outputs("midrst");
        @(posedge sysClk);
        #1;
        sysReset = 1'b0;
        tx_q = frame_q[3:NB-1];
        send(1'b1, 1'b0, 1'b1);
        m_short++;
        check_counts("frag");
        send_good(rand_rec(1'b0), 1'b1, 1'b0);
        wait_idle();
        check_counts("after_rst");

        sysLogTDATA  = $urandom;
        sysLogTVALID = 1'b1;
        sysLogTLAST  = 1'b1;
        repeat (65540) @(posedge sysClk);
        #1;
        sysLogTVALID = 1'b0;
        sysLogTLAST  = 1'b0;
        m_short += 65540;
        check_counts("sat");
        send_good(rand_rec(1'b0), 1'b0, 1'b0);
        wait_idle();
        check_counts("sat_good");

        send_good(rand_rec(1'b0), 1'b0, 1'b1);
        wait_idle();
        check_counts("clear");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/log_stream_unpacker.md
Name: log_stream_unpacker

Overview:
Receiver for the mitigation-node logging AXI stream; the consuming end of the log-record producer. It reassembles multi-beat log records, MSB word first, into one wide register, checks the framing, and unpacks the fields. Each record is presented on a valid/ready record port for the readback, replay and verification logic. All logic runs in the system clock domain.

Parameters:
TIMESTAMP_WIDTH, 64, timestamp field width
INTERLOCKS_PER_NODE, 64, width of each of the input-state and input-transition fields
AXI_WIDTH, 32, stream word width
ACQ_INDEX_WIDTH, 3, acquisition index width
MAX_OUTPUTS (localparam), 16, mitigation output field width
REC_WIDTH (localparam), 1+ACQ_INDEX_WIDTH+MAX_OUTPUTS+TIMESTAMP_WIDTH+2*INTERLOCKS_PER_NODE, record width (212 at defaults)
BEATS (localparam), ceil(REC_WIDTH/AXI_WIDTH), beats per record (7 at defaults)

Ports:
sysClk  in  1  system clock
sysReset  in  1  asynchronous, active-high reset
sysLogTDATA  in  AXI_WIDTH  stream data
sysLogTVALID  in  1  stream valid
sysLogTLAST  in  1  last beat of record
sysLogTREADY  out  1  stream ready
recValid  out  1  unpacked record available
recReady  in  1  consumer accepts record
recStrobeFlag  out  1  record bit REC_WIDTH-1 (new-data strobe)
recAcqIndex  out  ACQ_INDEX_WIDTH  acquisition index
recOutputState  out  MAX_OUTPUTS  mitigation output state
recTimestamp  out  TIMESTAMP_WIDTH  timestamp
recInputState  out  INTERLOCKS_PER_NODE  interlock input states
recInputTransitions  out  INTERLOCKS_PER_NODE  interlock transitions
recPadError  out  1  header pad bits of this record were nonzero
sysCountClear  in  1  synchronous clear of the counters
recordCount  out  16  saturating count of good records
shortErrCount  out  16  saturating count of short records
longErrCount  out  16  saturating count of long records

Behaviour:
- Reset values:
  - All outputs 0 except sysLogTREADY, which is 1.
  - State is COLLECT, beat counter 0, assembly register cleared.
  - A reset mid-record discards the partial record. The remaining upstream fragment is then caught by the framing checks.
- Record layout, MSB to LSB: strobe, acqIndex, outputs[MAX_OUTPUTS], timestamp, inputState, inputTransitions.
  - Beat 0 carries the top REC_WIDTH-(BEATS-1)*AXI_WIDTH bits (20 at defaults), right-justified, zero-padded above.
  - Each later beat carries the next lower AXI_WIDTH bits.
- Beat acceptance: a beat is accepted on a cycle with sysLogTVALID && sysLogTREADY. Assembly is a left shift: asm <= {asm, TDATA}, width BEATS*AXI_WIDTH.
- State machine:
  - COLLECT (TREADY=1): each accepted beat increments the beat counter b, which runs 0..BEATS-1.
    - TLAST with b<BEATS-1: drop the record, increment shortErrCount, set b=0, stay in COLLECT.
    - b==BEATS-1 with TLAST: latch the fields from asm[REC_WIDTH-1:0], including the final beat. Set recPadError = |(beat-0 pad bits). Go to HOLD, set b=0, increment recordCount.
    - b==BEATS-1 without TLAST: drop the record, increment longErrCount, go to DISCARD.
  - DISCARD (TREADY=1): consume beats until a beat with TLAST is accepted, then go to COLLECT with b=0. No further counts are taken.
  - HOLD (TREADY=0): recValid=1, with the fields stable. When recReady=1, recValid goes to 0 on the next edge and the state returns to COLLECT.
- Latency and throughput:
  - recValid rises on the edge after the final beat is accepted.
  - At least one TREADY-low cycle separates records. Peak throughput is BEATS+1 cycles per record.
- Counters:
  - Each counter is 16-bit and saturates at 0xFFFF.
  - sysCountClear zeroes all three counters and wins over a simultaneous increment.
  - The counters are independent of recReady.
- A record with nonzero pad is still delivered and still counted as good; only recPadError flags it.
- TVALID low mid-record leaves the state and counters unchanged. There is no timeout.

Test Plan:
- Good record: stream 7 beats encoding strobe=1, acqIndex=5, outputs=0x000A, timestamp=0x0123456789ABCDEF, inputState=0xFFFF0000FFFF0000, transitions=0x1, with TLAST on beat 6. Required: recValid on the next cycle with all fields exact, recPadError=0, recordCount=1.
- Short record: TLAST on beat 3, then a good record. Required: the first record is not delivered, shortErrCount=1; the second is delivered intact, recordCount=1.
- Long record: 9 beats with TLAST only on beat 8, then a good record. Required: longErrCount=1, nothing delivered from the long record, the next record is correct.
- Backpressure: hold recReady=0 for 20 cycles while a second record is offered. Required: TREADY=0 throughout, the first record's fields stay stable, and the second record is received intact after recReady pulses.
- Pad error: set beat 0 to 0x80000000 | header. Required: the record is delivered with recPadError=1 and recordCount is incremented.
- Reset and counters: assert sysReset after beat 2, then send beats 3..6 (TLAST on 6) followed by a good record. Required: outputs are 0 during reset; shortErrCount=1 after the fragment; the good record is decoded. Preload recordCount to 0xFFFF and send another good record: the count stays 0xFFFF. Assert sysCountClear on the same cycle as an increment: the counters read 0.
